// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage.
//
// Drives the program counter into instruction memory, buffers the returned
// ARM instruction words and presents them in order to decode through a
// valid/ready handshake. A taken branch from execute flushes the buffer,
// restarts fetch at the target and discards responses still in flight.
//
// Optional feature macro: FETCH_BRANCH_PREDICT_EN
//   When defined, popping an unconditional B/BL (cond=AL, op=101) from the
//   head redirects fetch internally and flags the entry with inst_predicted.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   imem_req / imem_addr       fetch request and word-aligned address
//   imem_gnt                   memory accepts the request this cycle
//   imem_rvalid / imem_rdata   in-order response
//   br_taken / br_target       execute-stage redirect
//   inst_valid / inst_ready    decode handshake
//   inst / inst_pc             head instruction word and its address
//   inst_predicted             fetch already redirected on this instruction
module fetch_unit #(
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_predicted
);

  localparam int unsigned      CNT_W    = $clog2(BUF_DEPTH + 1);
  localparam int unsigned      PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [31:0]      START_PC = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(BUF_DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      buf_inst_q [BUF_DEPTH];
  logic [31:0]      buf_inst_d [BUF_DEPTH];
  logic [31:0]      buf_pc_q   [BUF_DEPTH];
  logic [31:0]      buf_pc_d   [BUF_DEPTH];

  logic             rv_eff_s, pop_s, push_s, gnt_fire_s;
  logic             redirect_s, pred_redir_s, head_is_b_s;
  logic [31:0]      head_inst_s, head_pc_s, pred_target_s, redir_target_s;
  logic [CNT_W:0]   credit_used_s;

  // Circular pointer advance for a buffer depth that need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Head-of-buffer decode and predicted-branch target.
  always_comb begin
    head_inst_s = buf_inst_q[rd_ptr_q];
    head_pc_s   = buf_pc_q[rd_ptr_q];
`ifdef FETCH_BRANCH_PREDICT_EN
    head_is_b_s   = (head_inst_s[31:28] == 4'hE) && (head_inst_s[27:25] == 3'b101);
    // ARM branch: PC reads as instruction address + 8, offset is in words.
    pred_target_s = head_pc_s + 32'd8 + {{6{head_inst_s[23]}}, head_inst_s[23:0], 2'b00};
`else
    head_is_b_s   = 1'b0;
    pred_target_s = 32'h0000_0000;
`endif
  end

  // Handshake, credit and next-state computation.
  always_comb begin
    // A response with nothing outstanding is a protocol violation: ignore it.
    rv_eff_s       = imem_rvalid && (outstanding_q != {CNT_W{1'b0}});
    pop_s          = inst_valid && inst_ready;
    pred_redir_s   = pop_s && head_is_b_s && !br_taken;
    redirect_s     = br_taken || pred_redir_s;
    redir_target_s = br_taken ? (br_target & 32'hFFFF_FFFC) : pred_target_s;
    // A pop this cycle frees a slot before any new response can land,
    // which is what sustains one instruction per cycle.
    credit_used_s  = {1'b0, outstanding_q} + {1'b0, count_q} - {{CNT_W{1'b0}}, pop_s};
    imem_req       = !reset && !redirect_s && (credit_used_s < DEPTH_C);
    gnt_fire_s     = imem_req && imem_gnt;
    push_s         = rv_eff_s && !redirect_s && (drop_q == {CNT_W{1'b0}});

    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    buf_inst_d    = buf_inst_q;
    buf_pc_d      = buf_pc_q;

    if (redirect_s) begin
      // Everything still in flight (minus a response landing now) is stale.
      pc_d          = redir_target_s;
      resp_pc_d     = redir_target_s;
      outstanding_d = outstanding_q - CNT_W'(rv_eff_s);
      drop_d        = outstanding_q - CNT_W'(rv_eff_s);
      count_d       = {CNT_W{1'b0}};
      rd_ptr_d      = {PTR_W{1'b0}};
      wr_ptr_d      = {PTR_W{1'b0}};
    end else begin
      if (gnt_fire_s) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
      outstanding_d = outstanding_q + CNT_W'(gnt_fire_s) - CNT_W'(rv_eff_s);
      if (rv_eff_s && (drop_q != {CNT_W{1'b0}})) begin
        drop_d = drop_q - CNT_W'(1);
      end else begin
        drop_d = drop_q;
      end
      if (push_s) begin
        buf_inst_d[wr_ptr_q] = imem_rdata;
        buf_pc_d[wr_ptr_q]   = resp_pc_q;
        wr_ptr_d             = ptr_inc(wr_ptr_q);
        resp_pc_d            = resp_pc_q + 32'd4;
      end else begin
        wr_ptr_d  = wr_ptr_q;
        resp_pc_d = resp_pc_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= START_PC;
      resp_pc_q     <= START_PC;
      outstanding_q <= {CNT_W{1'b0}};
      drop_q        <= {CNT_W{1'b0}};
      count_q       <= {CNT_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      wr_ptr_q      <= {PTR_W{1'b0}};
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        buf_inst_q[i] <= 32'h0000_0000;
        buf_pc_q[i]   <= 32'h0000_0000;
      end
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      buf_inst_q    <= buf_inst_d;
      buf_pc_q      <= buf_pc_d;
    end
  end

  // Outputs come straight from registered state; data reads zero when empty.
  assign imem_addr      = pc_q;
  assign inst_valid     = (count_q != {CNT_W{1'b0}});
  assign inst           = inst_valid ? head_inst_s : 32'h0000_0000;
  assign inst_pc        = inst_valid ? head_pc_s : 32'h0000_0000;
  assign inst_predicted = inst_valid && head_is_b_s;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
// A behavioural memory (in-order, fixed latency) feeds the DUT; a program
// order model (next expected PC, restarted on every redirect) checks every
// instruction decode sees, the fetch address stream and the credit bound.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;
`ifdef FETCH_BRANCH_PREDICT_EN
  localparam logic PRED_EN = 1'b1;
`else
  localparam logic PRED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_predicted;

  fetch_unit #(.BUF_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .br_taken(br_taken), .br_target(br_target),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_predicted(inst_predicted)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t        mq[$];
  int          mem_lat = 1;
  logic        ovr_en = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] fetch_exp = RST_PC;
  logic        expect_inv = 1'b0;
  logic        rst_prev = 1'b1;
  logic        obs_valid, obs_req, obs_pred;
  logic [31:0] obs_pc, obs_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr_en && a == 32'h0000_0040) return 32'hEAFF_FFFE;
    return {4'h1, a[27:0] ^ 28'h5A3_C96B};
  endfunction

  function automatic logic is_b(input logic [31:0] w);
    return (w[31:28] == 4'hE) && (w[27:25] == 3'b101);
  endfunction

  // One clock cycle: drive at negedge, settle, check, then advance to next negedge.
  task automatic step(input logic rst, input logic br, input logic [31:0] tgt,
                      input logic rdy, input logic gnt);
    logic        pop_v;
    logic [31:0] w;
    reset = rst; br_taken = br; br_target = tgt; inst_ready = rdy; imem_gnt = gnt;
    if (rst) mq.delete();
    if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1; imem_rdata = mem_word(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = 32'h0;
    end
    #1;
    obs_valid = inst_valid; obs_pc = inst_pc; obs_req = imem_req;
    obs_addr = imem_addr; obs_pred = inst_predicted;
    if (rst_prev) begin
      check_eq("rst_valid", {31'h0, inst_valid}, 32'h0);
      check_eq("rst_inst", inst, 32'h0);
      check_eq("rst_pc", inst_pc, 32'h0);
      check_eq("rst_pred", {31'h0, inst_predicted}, 32'h0);
      check_eq("rst_addr", imem_addr, RST_PC);
    end
    if (rst) begin
      check_eq("rst_req", {31'h0, imem_req}, 32'h0);
      exp_pc = RST_PC; fetch_exp = RST_PC; expect_inv = 1'b0;
    end else begin
      if (br) check_eq("br_req", {31'h0, imem_req}, 32'h0);
      if (expect_inv) check_eq("post_redir_valid", {31'h0, inst_valid}, 32'h0);
      if (imem_req) check_eq("fetch_addr", imem_addr, fetch_exp);
      if (imem_req && gnt) begin
        check_eq("credit", mq.size(), (mq.size() < DEPTH) ? mq.size() : DEPTH - 1);
        mq.push_back('{addr: imem_addr, due: cyc + mem_lat});
        fetch_exp = fetch_exp + 32'd4;
      end
      pop_v = inst_valid && rdy;
      w = mem_word(exp_pc);
      if (inst_valid) begin
        check_eq("inst_pc", inst_pc, exp_pc);
        check_eq("inst_word", inst, w);
        check_eq("inst_pred", {31'h0, inst_predicted}, {31'h0, PRED_EN && is_b(w)});
      end
      if (br) begin
        exp_pc = tgt & 32'hFFFF_FFFC; fetch_exp = exp_pc; expect_inv = 1'b1;
      end else if (pop_v && PRED_EN && is_b(w)) begin
        exp_pc = exp_pc + 32'd8 + {{6{w[23]}}, w[23:0], 2'b00};
        fetch_exp = exp_pc; expect_inv = 1'b1;
      end else begin
        if (pop_v) exp_pc = exp_pc + 32'd4;
        expect_inv = 1'b0;
      end
    end
    if (imem_rvalid) void'(mq.pop_front());
    rst_prev = rst;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int lat);
    mem_lat = lat;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    @(negedge clk);

    // Latency and steady-state throughput.
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (i < 2) check_eq("lat_not_yet", {31'h0, obs_valid}, 32'h0);
      else begin
        check_eq("lat_valid", {31'h0, obs_valid}, 32'h1);
        check_eq("lat_pc", obs_pc, RST_PC + 32'(4 * (i - 2)));
      end
    end

    // Decode stall: fetch must back off, nothing lost on release.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("stall_req", {31'h0, obs_req}, 32'h0);
    check_eq("stall_valid", {31'h0, obs_valid}, 32'h1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Grant withheld: address holds at 0x108.
    do_reset(1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      check_eq("hold_req", {31'h0, obs_req}, 32'h1);
      check_eq("hold_addr", obs_addr, 32'h0000_0108);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect with two fetches in flight on a 3-cycle memory.
    do_reset(3);
    n = 0;
    while (mq.size() < 2 && n < 10) begin step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); n++; end
    check_eq("br_inflight", mq.size(), 2);
    step(1'b0, 1'b1, 32'h0000_0203, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("br_gap", {31'h0, obs_valid}, 32'h0);
    n = 0;
    do begin step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); n++; end while (!obs_valid && n < 20);
    check_eq("br_first_valid", {31'h0, obs_valid}, 32'h1);
    check_eq("br_first_pc", obs_pc, 32'h0000_0200);

    // Reset mid-operation with buffered and outstanding words.
    do_reset(3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    do_reset(1);
    n = 0;
    do begin step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); n++; end while (!obs_valid && n < 10);
    check_eq("restart_pc", obs_pc, RST_PC);

    // Unconditional branch-to-self at 0x40.
    ovr_en = 1'b1;
    do_reset(1);
    step(1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b1);
    n = 0;
    do begin step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); n++; end
    while (!(obs_valid && obs_pc == 32'h40) && n < 20);
    check_eq("bp_seen", obs_pc, 32'h0000_0040);
    check_eq("bp_pred", {31'h0, obs_pred}, {31'h0, PRED_EN});
    n = 0;
    do begin step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); n++; end while (!obs_valid && n < 20);
    check_eq("bp_next_pc", obs_pc, PRED_EN ? 32'h0000_0040 : 32'h0000_0044);
    do_reset(1);
    ovr_en = 1'b0;

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) do_reset($urandom_range(1, 3));
      step(1'b0, ($urandom_range(0, 24) == 0), $urandom,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
